// File: rtl/arm_pkg.sv
`default_nettype none
// ============================================================
// Package : arm_pkg
// Instruction-class, opcode and shift-type encodings shared by
// the execute slice.
// Rev     : 1.0
// ============================================================
package arm_pkg;

  localparam logic [2:0] c_cls_dp_reg = 3'b000;
  localparam logic [2:0] c_cls_dp_imm = 3'b001;
  localparam logic [2:0] c_cls_ls_imm = 3'b010;
  localparam logic [2:0] c_cls_ls_reg = 3'b011;
  localparam logic [2:0] c_cls_branch = 3'b101;

  localparam logic [3:0] c_op_and = 4'd0;
  localparam logic [3:0] c_op_eor = 4'd1;
  localparam logic [3:0] c_op_sub = 4'd2;
  localparam logic [3:0] c_op_rsb = 4'd3;
  localparam logic [3:0] c_op_add = 4'd4;
  localparam logic [3:0] c_op_adc = 4'd5;
  localparam logic [3:0] c_op_sbc = 4'd6;
  localparam logic [3:0] c_op_rsc = 4'd7;
  localparam logic [3:0] c_op_tst = 4'd8;
  localparam logic [3:0] c_op_teq = 4'd9;
  localparam logic [3:0] c_op_cmp = 4'd10;
  localparam logic [3:0] c_op_cmn = 4'd11;
  localparam logic [3:0] c_op_orr = 4'd12;
  localparam logic [3:0] c_op_mov = 4'd13;
  localparam logic [3:0] c_op_bic = 4'd14;
  localparam logic [3:0] c_op_mvn = 4'd15;

  localparam logic [1:0] c_sh_lsl = 2'b00;
  localparam logic [1:0] c_sh_lsr = 2'b01;
  localparam logic [1:0] c_sh_asr = 2'b10;
  localparam logic [1:0] c_sh_ror = 2'b11;

endpackage
`default_nettype wire

// File: rtl/arm_shifter.sv
`default_nettype none
// ============================================================
// Module : arm_shifter
// Combinational barrel shifter producing shifter_operand and
// its carry-out for immediate, register and rotated-imm forms.
// Rev    : 1.0
// ============================================================
module arm_shifter
  import arm_pkg::*;
(
  input  logic [31:0] shift_in,
  input  logic [4:0]  shift_imm,
  input  logic [7:0]  rs_value,
  input  logic        carry_in,
  input  logic [1:0]  shift_type,
  input  logic        use_rs,
  input  logic        use_imm32,
  output logic [31:0] result,
  output logic        carry_out
);

  logic        w_rs_ge32;
  logic        w_rs_gt32;
  logic [5:0]  w_amt;
  logic [4:0]  w_rot;
  logic [32:0] w_lsl;
  logic [32:0] w_lsr;
  logic [32:0] w_asr;
  logic [31:0] w_ror;

  assign w_rs_ge32 = (rs_value >= 8'd32);
  assign w_rs_gt32 = (rs_value > 8'd32);

  // Amount saturates at 32; immediate #0 encodes #32 for LSR/ASR.
  assign w_amt = use_rs ? (w_rs_ge32 ? 6'd32 : rs_value[5:0])
                        : ((shift_imm == 5'd0) ? 6'd32 : {1'b0, shift_imm});
  assign w_rot = use_imm32 ? {shift_imm[3:0], 1'b0}
                           : (use_rs ? rs_value[4:0] : shift_imm);

  // Extra guard bit carries the last bit shifted out.
  assign w_lsl = {1'b0, shift_in} << w_amt;
  assign w_lsr = {shift_in, 1'b0} >> w_amt;
  assign w_asr = $signed({shift_in, 1'b0}) >>> w_amt;
  assign w_ror = 32'({shift_in, shift_in} >> w_rot);

  always_comb begin
    result    = shift_in;
    carry_out = carry_in;
    if (use_imm32) begin
      result    = w_ror;
      carry_out = (w_rot == 5'd0) ? carry_in : w_ror[31];
    end else if (!(use_rs && rs_value == 8'd0)) begin
      case (shift_type)
        c_sh_lsl: begin
          if (use_rs && w_rs_gt32) begin
            result    = 32'd0;
            carry_out = 1'b0;
          end else if (use_rs || shift_imm != 5'd0) begin
            result    = w_lsl[31:0];
            carry_out = w_lsl[32];
          end
        end
        c_sh_lsr: begin
          if (use_rs && w_rs_gt32) begin
            result    = 32'd0;
            carry_out = 1'b0;
          end else begin
            result    = w_lsr[32:1];
            carry_out = w_lsr[0];
          end
        end
        c_sh_asr: begin
          result    = w_asr[32:1];
          carry_out = w_asr[0];
        end
        default: begin
          if (!use_rs && shift_imm == 5'd0) begin
            result    = {carry_in, shift_in[31:1]};
            carry_out = shift_in[0];
          end else begin
            result    = w_ror;
            carry_out = w_ror[31];
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/arm_exec_unit.sv
`default_nettype none
// ============================================================
// Module : arm_exec_unit
// Registered instruction decoder plus combinational shifter and
// ALU for the ARMv4-style CPU execute stage.
// Rev    : 1.0
// ============================================================
module arm_exec_unit
  import arm_pkg::*;
(
  input  logic        clk,
  input  logic        n_reset,
  input  logic        decode_en,
  input  logic [31:0] instruction,
  output logic        valid,
  output logic [3:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rn,
  output logic [3:0]  rm,
  output logic [3:0]  rs,
  output logic [3:0]  rotate_imm,
  output logic [1:0]  shift,
  output logic [4:0]  shift_amount,
  output logic [7:0]  imm8,
  output logic        use_rs,
  output logic        use_imm32,
  output logic        is_load,
  output logic        is_unsigned_byte,
  output logic        is_not_postindex,
  output logic        is_added_offset,
  output logic        is_write_back,
  output logic [11:0] offset_12,
  output logic        branch_with_link,
  output logic [23:0] signed_immed_24,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] shift_in,
  input  logic [4:0]  shift_imm,
  input  logic [7:0]  rs_value,
  input  logic        carry_in,
  input  logic        alu_en,
  input  logic [31:0] operand1,
  output logic [31:0] shifter_operand,
  output logic        shifter_carry,
  output logic [31:0] alu_result,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_v,
  output logic        writes_rd
);

  logic [2:0] w_cls;
  logic       w_is_ls;

  assign w_cls   = instruction[27:25];
  assign w_is_ls = (w_cls[2:1] == 2'b01);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      valid            <= 1'b0;
      opcode           <= '0;
      rd               <= '0;
      rn               <= '0;
      rm               <= '0;
      rs               <= '0;
      rotate_imm       <= '0;
      shift            <= '0;
      shift_amount     <= '0;
      imm8             <= '0;
      use_rs           <= 1'b0;
      use_imm32        <= 1'b0;
      is_load          <= 1'b0;
      is_unsigned_byte <= 1'b0;
      is_not_postindex <= 1'b0;
      is_added_offset  <= 1'b0;
      is_write_back    <= 1'b0;
      offset_12        <= '0;
      branch_with_link <= 1'b0;
      signed_immed_24  <= '0;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
    end else begin
      valid <= decode_en;
      if (decode_en) begin
        opcode           <= instruction[24:21];
        rn               <= instruction[19:16];
        rd               <= instruction[15:12];
        rs               <= instruction[11:8];
        rm               <= instruction[3:0];
        rotate_imm       <= instruction[11:8];
        shift            <= instruction[6:5];
        shift_amount     <= instruction[11:7];
        imm8             <= instruction[7:0];
        use_imm32        <= (w_cls == c_cls_dp_imm);
        use_rs           <= (w_cls == c_cls_dp_reg) & instruction[4];
        is_not_postindex <= instruction[24];
        is_added_offset  <= instruction[23];
        is_unsigned_byte <= instruction[22];
        is_write_back    <= instruction[21];
        is_load          <= instruction[20];
        offset_12        <= instruction[11:0];
        signed_immed_24  <= instruction[23:0];
        mem_read         <= w_is_ls & instruction[20];
        mem_write        <= w_is_ls & ~instruction[20];
        branch_with_link <= (w_cls == c_cls_branch) & instruction[24];
      end
    end
  end

  arm_shifter u_shifter (
    .shift_in   (shift_in),
    .shift_imm  (shift_imm),
    .rs_value   (rs_value),
    .carry_in   (carry_in),
    .shift_type (shift),
    .use_rs     (use_rs),
    .use_imm32  (use_imm32),
    .result     (shifter_operand),
    .carry_out  (shifter_carry)
  );

  logic [31:0] w_x;
  logic [31:0] w_y;
  logic        w_ci;
  logic        w_arith;
  logic [32:0] w_sum;
  logic [31:0] w_res;

  // Subtracts become x + ~y + ci so one adder serves every arithmetic op.
  always_comb begin
    w_x     = operand1;
    w_y     = shifter_operand;
    w_ci    = 1'b0;
    w_arith = 1'b1;
    case (opcode)
      c_op_sub, c_op_cmp: begin
        w_y  = ~shifter_operand;
        w_ci = 1'b1;
      end
      c_op_rsb: begin
        w_x  = shifter_operand;
        w_y  = ~operand1;
        w_ci = 1'b1;
      end
      c_op_add, c_op_cmn: begin
        w_ci = 1'b0;
      end
      c_op_adc: begin
        w_ci = carry_in;
      end
      c_op_sbc: begin
        w_y  = ~shifter_operand;
        w_ci = carry_in;
      end
      c_op_rsc: begin
        w_x  = shifter_operand;
        w_y  = ~operand1;
        w_ci = carry_in;
      end
      default: w_arith = 1'b0;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {32'd0, w_ci};

  always_comb begin
    case (opcode)
      c_op_and, c_op_tst: w_res = operand1 & shifter_operand;
      c_op_eor, c_op_teq: w_res = operand1 ^ shifter_operand;
      c_op_orr:           w_res = operand1 | shifter_operand;
      c_op_mov:           w_res = shifter_operand;
      c_op_bic:           w_res = operand1 & ~shifter_operand;
      c_op_mvn:           w_res = ~shifter_operand;
      default:            w_res = w_sum[31:0];
    endcase
  end

  assign alu_result = alu_en ? w_res : 32'd0;
  assign flag_n     = alu_en & w_res[31];
  assign flag_z     = alu_en & (w_res == 32'd0);
  assign flag_c     = alu_en & (w_arith ? w_sum[32] : shifter_carry);
  assign flag_v     = alu_en & w_arith & (w_x[31] == w_y[31]) & (w_sum[31] != w_x[31]);
  assign writes_rd  = alu_en & (opcode[3:2] != 2'b10);

endmodule
`default_nettype wire

// File: tb/tb_arm_exec_unit.sv
`default_nettype none
// ============================================================
// Module : tb_arm_exec_unit
// Self-checking bench: directed cases plus randomized decode,
// shifter and ALU checks against a behavioural model.
// Rev    : 1.0
// ============================================================
module tb_arm_exec_unit;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        decode_en;
  logic [31:0] instruction;
  logic        valid;
  logic [3:0]  opcode, rd, rn, rm, rs, rotate_imm;
  logic [1:0]  shift;
  logic [4:0]  shift_amount;
  logic [7:0]  imm8;
  logic        use_rs, use_imm32;
  logic        is_load, is_unsigned_byte, is_not_postindex, is_added_offset, is_write_back;
  logic [11:0] offset_12;
  logic        branch_with_link;
  logic [23:0] signed_immed_24;
  logic        mem_read, mem_write;
  logic [31:0] shift_in;
  logic [4:0]  shift_imm;
  logic [7:0]  rs_value;
  logic        carry_in;
  logic        alu_en;
  logic [31:0] operand1;
  logic [31:0] shifter_operand;
  logic        shifter_carry;
  logic [31:0] alu_result;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        writes_rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arm_exec_unit dut (
    .clk(clk), .n_reset(n_reset), .decode_en(decode_en), .instruction(instruction),
    .valid(valid), .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .rs(rs),
    .rotate_imm(rotate_imm), .shift(shift), .shift_amount(shift_amount), .imm8(imm8),
    .use_rs(use_rs), .use_imm32(use_imm32), .is_load(is_load),
    .is_unsigned_byte(is_unsigned_byte), .is_not_postindex(is_not_postindex),
    .is_added_offset(is_added_offset), .is_write_back(is_write_back),
    .offset_12(offset_12), .branch_with_link(branch_with_link),
    .signed_immed_24(signed_immed_24), .mem_read(mem_read), .mem_write(mem_write),
    .shift_in(shift_in), .shift_imm(shift_imm), .rs_value(rs_value),
    .carry_in(carry_in), .alu_en(alu_en), .operand1(operand1),
    .shifter_operand(shifter_operand), .shifter_carry(shifter_carry),
    .alu_result(alu_result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v), .writes_rd(writes_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-serial shifter model: one single-bit step per iteration, tracking the bit that falls out.
  function automatic logic [32:0] m_shift(input logic [31:0] x, input logic [4:0] simm,
                                          input logic [7:0] rsv, input logic cin,
                                          input logic [1:0] st, input logic urs, input logic ui32);
    logic [31:0] v;
    logic        c;
    int          n;
    v = x;
    c = cin;
    if (ui32) begin
      n = 2 * int'(simm[3:0]);
      for (int i = 0; i < n; i++) begin
        v = {v[0], v[31:1]};
        c = v[31];
      end
      return {c, v};
    end
    if (urs) n = int'(rsv);
    else begin
      n = int'(simm);
      if (simm == 5'd0) begin
        if (st == 2'd3) return {x[0], cin, x[31:1]};
        n = (st == 2'd0) ? 0 : 32;
      end
    end
    for (int i = 0; i < n; i++) begin
      case (st)
        2'd0:    begin c = v[31]; v = {v[30:0], 1'b0}; end
        2'd1:    begin c = v[0];  v = {1'b0, v[31:1]}; end
        2'd2:    begin c = v[0];  v = {v[31], v[31:1]}; end
        default: begin c = v[0];  v = {v[0], v[31:1]}; end
      endcase
    end
    return {c, v};
  endfunction

  // Returns {writes_rd, N, Z, C, V, result[31:0]} from wide integer arithmetic.
  function automatic logic [36:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin,
                                        input logic sc, input logic en);
    longint ua, ub, sa, sb, full, sres, ci;
    logic [31:0] r;
    logic c, v, arith;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ci = cin ? 64'sd1 : 64'sd0;
    arith = 1'b1; full = 0; sres = 0;
    case (op)
      4'd2, 4'd10: begin full = ua - ub;          sres = sa - sb;          c = (full >= 0); end
      4'd3:        begin full = ub - ua;          sres = sb - sa;          c = (full >= 0); end
      4'd4, 4'd11: begin full = ua + ub;          sres = sa + sb;          c = (full > 64'hFFFFFFFF); end
      4'd5:        begin full = ua + ub + ci;     sres = sa + sb + ci;     c = (full > 64'hFFFFFFFF); end
      4'd6:        begin full = ua - ub - (1-ci); sres = sa - sb - (1-ci); c = (full >= 0); end
      4'd7:        begin full = ub - ua - (1-ci); sres = sb - sa - (1-ci); c = (full >= 0); end
      default:     begin arith = 1'b0; c = sc; end
    endcase
    case (op)
      4'd0, 4'd8: r = a & b;
      4'd1, 4'd9: r = a ^ b;
      4'd12:      r = a | b;
      4'd13:      r = b;
      4'd14:      r = a & ~b;
      4'd15:      r = ~b;
      default:    r = full[31:0];
    endcase
    v = arith && ((sres > 64'sd2147483647) || (sres < -64'sd2147483648));
    if (!en) return 37'd0;
    return {!(op >= 4'd8 && op <= 4'd11), r[31], (r == 32'd0), c, v, r};
  endfunction

  task automatic do_decode(input logic [31:0] ir);
    @(negedge clk);
    decode_en   = 1'b1;
    instruction = ir;
    @(negedge clk);
    decode_en   = 1'b0;
  endtask

  task automatic chk_decode(input logic [31:0] ir);
    logic [2:0] cls;
    logic       ls;
    cls = ir[27:25];
    ls  = (cls == 3'b010) || (cls == 3'b011);
    chk("valid",      valid,            1'b1);
    chk("opcode",     opcode,           ir[24:21]);
    chk("rn",         rn,               ir[19:16]);
    chk("rd",         rd,               ir[15:12]);
    chk("rs",         rs,               ir[11:8]);
    chk("rm",         rm,               ir[3:0]);
    chk("rotate_imm", rotate_imm,       ir[11:8]);
    chk("shift",      shift,            ir[6:5]);
    chk("shift_amt",  shift_amount,     ir[11:7]);
    chk("imm8",       imm8,             ir[7:0]);
    chk("use_imm32",  use_imm32,        cls == 3'b001);
    chk("use_rs",     use_rs,           (cls == 3'b000) && ir[4]);
    chk("lsbits",     {is_not_postindex, is_added_offset, is_unsigned_byte, is_write_back, is_load},
                      ir[24:20]);
    chk("offset_12",  offset_12,        ir[11:0]);
    chk("simm24",     signed_immed_24,  ir[23:0]);
    chk("mem_read",   mem_read,         ls && ir[20]);
    chk("mem_write",  mem_write,        ls && !ir[20]);
    chk("bl",         branch_with_link, (cls == 3'b101) && ir[24]);
  endtask

  task automatic chk_exec(input logic [31:0] ir);
    logic [32:0] es;
    logic [36:0] ea;
    es = m_shift(shift_in, shift_imm, rs_value, carry_in, ir[6:5],
                 (ir[27:25] == 3'b000) && ir[4], ir[27:25] == 3'b001);
    ea = m_alu(ir[24:21], operand1, es[31:0], carry_in, es[32], alu_en);
    chk("sh_res",    shifter_operand, es[31:0]);
    chk("sh_carry",  shifter_carry,   es[32]);
    chk("alu_res",   alu_result,      ea[31:0]);
    chk("flags_nzcv", {flag_n, flag_z, flag_c, flag_v}, ea[35:32]);
    chk("writes_rd", writes_rd,       ea[36]);
  endtask

  initial begin
    logic [31:0] ir;
    n_reset = 1'b0; decode_en = 1'b0; instruction = '0;
    shift_in = '0; shift_imm = '0; rs_value = '0; carry_in = 1'b0;
    alu_en = 1'b0; operand1 = '0;
    #12;
    chk("rst_valid",  valid,  1'b0);
    chk("rst_fields", {opcode, rd, rn, rm, offset_12, signed_immed_24, mem_read, mem_write}, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;

    // MOV r1,#5
    do_decode(32'hE3A01005);
    chk("mov_valid", valid, 1'b1);
    chk("mov_opcode", opcode, 4'b1101);
    chk("mov_rd", rd, 4'd1);
    chk("mov_imm32", use_imm32, 1'b1);
    chk("mov_imm8", imm8, 8'h05);
    chk("mov_rot", rotate_imm, 4'd0);
    chk("mov_mrd", mem_read, 1'b0);

    // LDR r2,[r1,#4]
    do_decode(32'hE5912004);
    chk("ldr_load", is_load, 1'b1);
    chk("ldr_mrd", mem_read, 1'b1);
    chk("ldr_u", is_added_offset, 1'b1);
    chk("ldr_p", is_not_postindex, 1'b1);
    chk("ldr_rn", rn, 4'd1);
    chk("ldr_off", offset_12, 12'h004);
    @(negedge clk);
    chk("ldr_drop_valid", valid, 1'b0);
    chk("ldr_hold_off", offset_12, 12'h004);

    // Shifter corner cases
    alu_en = 1'b1;
    shift_in = 32'h80000001; carry_in = 1'b0; shift_imm = 5'd0;
    do_decode(32'hE1A00021);
    #1;
    chk("lsr0_res", shifter_operand, 32'h0);
    chk("lsr0_c", shifter_carry, 1'b1);
    do_decode(32'hE1A00061);
    carry_in = 1'b1;
    #1;
    chk("rrx_res", shifter_operand, 32'hC0000000);
    chk("rrx_c", shifter_carry, 1'b1);
    do_decode(32'hE3A000FF);
    shift_in = 32'hFF; shift_imm = 5'd4; carry_in = 1'b0;
    #1;
    chk("imm32_res", shifter_operand, 32'hFF000000);
    chk("imm32_c", shifter_carry, 1'b1);

    // ALU directed
    do_decode(32'hE0810002);
    shift_imm = 5'd0; shift_in = 32'd1; operand1 = 32'h7FFFFFFF; carry_in = 1'b0;
    #1;
    chk("add_ovf_res", alu_result, 32'h80000000);
    chk("add_ovf_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b1001);
    operand1 = 32'hFFFFFFFF;
    #1;
    chk("add_wrap_res", alu_result, 32'h0);
    chk("add_wrap_zc", {flag_z, flag_c}, 2'b11);
    alu_en = 1'b0;
    #1;
    chk("alu_off", {alu_result, flag_n, flag_z, flag_c, flag_v, writes_rd}, 37'd0);
    alu_en = 1'b1;
    do_decode(32'hE1510002);
    operand1 = 32'd5; shift_in = 32'd5;
    #1;
    chk("cmp_zc", {flag_z, flag_c}, 2'b11);
    chk("cmp_wrd", writes_rd, 1'b0);
    do_decode(32'hE0410002);
    operand1 = 32'd3; shift_in = 32'd5;
    #1;
    chk("sub_res", alu_result, 32'hFFFFFFFE);
    chk("sub_nc", {flag_n, flag_c}, 2'b10);

    // Reset asserted between decode edges
    @(negedge clk);
    decode_en = 1'b1; instruction = 32'hE3A01005;
    @(posedge clk);
    #2 n_reset = 1'b0;
    #1;
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_opcode", opcode, 4'd0);
    decode_en = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;

    // Randomized decode + execute
    for (int it = 0; it < 300; it++) begin
      ir = $urandom;
      if ($urandom_range(0, 1) == 1) ir[27:26] = 2'b00;
      do_decode(ir);
      chk_decode(ir);
      shift_in  = $urandom;
      operand1  = $urandom;
      shift_imm = 5'($urandom_range(0, 31));
      carry_in  = 1'($urandom_range(0, 1));
      alu_en    = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 4))
        0:       rs_value = 8'd0;
        1:       rs_value = 8'd32;
        2:       rs_value = 8'($urandom_range(33, 255));
        3:       rs_value = 8'($urandom_range(1, 31));
        default: rs_value = 8'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) operand1 = shift_in;
      #1;
      chk_exec(ir);
      @(negedge clk);
      chk("rnd_valid_drop", valid, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
